// File: rtl/counter_4bit.sv
// ---------------------------------------------------------------------------
// counter_4bit
//
// Free-running synchronous up-counter used as a timebase or sequence
// generator. It advances by STEP on every rising clock edge and wraps to 0
// whenever the next value would exceed MAX. There is no enable or load: the
// counter runs on every clock unless reset is asserted.
//
// Parameters
//   WIDTH  counter width in bits (count output width)
//   STEP   increment per clock, 1 .. (2**WIDTH)-1
//   MAX    terminal value, MAX <= (2**WIDTH)-1; the step that would pass
//          MAX lands on 0 instead
//
// Ports
//   clk    in   1      single clock, all state changes on the rising edge
//   reset  in   1      synchronous active-high reset, priority over counting
//   count  out  WIDTH  current value, driven straight from the register
//
// Handshake: none. The block has no valid/ready interface; count is valid on
// every cycle after the first reset edge and is undefined before it.
// ---------------------------------------------------------------------------
module counter_4bit #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    // Step and terminal value widened by one bit so count + STEP cannot
    // overflow before it is compared against MAX.
    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] MAX_W  = (WIDTH + 1)'(MAX);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, count} + STEP_W;

    // Reset is sampled only at the edge; between edges count simply holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (sum > MAX_W) begin
            count <= '0;
        end else begin
            count <= sum[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_counter_4bit.sv
// ---------------------------------------------------------------------------
// tb_counter_4bit
//
// Three instances share clk and reset: the default mod-16 counter, a
// decade counter (MAX=9) and a step-3 counter (STEP=3, MAX=15). Each edge
// the bench's own model computes the next value of all three; the packed
// expectation is queued before the edge and popped after it.
// ---------------------------------------------------------------------------
module tb_counter_4bit;

    logic       clk;
    logic       reset;
    logic [3:0] cnt_def;
    logic [3:0] cnt_dec;
    logic [3:0] cnt_st3;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: default, decade, step-3
    int m_def = 0;
    int m_dec = 0;
    int m_st3 = 0;

    logic [11:0] exp_q[$];

    counter_4bit #(.WIDTH(4), .STEP(1), .MAX(15)) u_def (
        .clk(clk), .reset(reset), .count(cnt_def)
    );
    counter_4bit #(.WIDTH(4), .STEP(1), .MAX(9)) u_dec (
        .clk(clk), .reset(reset), .count(cnt_dec)
    );
    counter_4bit #(.WIDTH(4), .STEP(3), .MAX(15)) u_st3 (
        .clk(clk), .reset(reset), .count(cnt_st3)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial reset = 1'b1;

    // ---------------- driver ----------------
    // Drive reset for the next edge, queue the model's prediction, then
    // advance to 1 ns after that edge where the outputs are sampled.
    task automatic tick(input logic r);
        reset = r;
        if (r) begin
            m_def = 0;
            m_dec = 0;
            m_st3 = 0;
        end else begin
            m_def = (m_def + 1 > 15) ? 0 : m_def + 1;
            m_dec = (m_dec + 1 > 9)  ? 0 : m_dec + 1;
            m_st3 = (m_st3 + 3 > 15) ? 0 : m_st3 + 3;
        end
        exp_q.push_back({4'(m_def), 4'(m_dec), 4'(m_st3)});
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] e;
        tick(1'b1);
        e = exp_q.pop_front();
        n_cmp++;
        if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
            n_fail++;
            $display("FAIL reset_state got=%h required=%h", {cnt_def, cnt_dec, cnt_st3}, e);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
                n_fail++;
                $display("FAIL powerup_count[%0d] got=%h required=%h", i, {cnt_def, cnt_dec, cnt_st3}, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] e;
        tick(1'b1);
        void'(exp_q.pop_front());
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
                n_fail++;
                $display("FAIL wrap_seq[%0d] got=%h required=%h", i, {cnt_def, cnt_dec, cnt_st3}, e);
            end
            if (i == 15 || i == 16 || i == 20) begin
                n_cmp++;
                if (cnt_def !== ((i == 15) ? 4'd15 : (i == 16) ? 4'd0 : 4'd4)) begin
                    n_fail++;
                    $display("FAIL wrap_point[%0d] got=%0d", i, cnt_def);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] e;
        tick(1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            tick(1'b0);
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (cnt_def !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_reset_pre got=%0d required=4", cnt_def);
        end
        tick(1'b1);
        e = exp_q.pop_front();
        n_cmp++;
        if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
            n_fail++;
            $display("FAIL mid_reset_clear got=%h required=%h", {cnt_def, cnt_dec, cnt_st3}, e);
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
                n_fail++;
                $display("FAIL mid_reset_resume[%0d] got=%h required=%h", i, {cnt_def, cnt_dec, cnt_st3}, e);
            end
        end
        n_cmp++;
        if (cnt_def !== 4'd10) begin
            n_fail++;
            $display("FAIL mid_reset_final got=%0d required=10", cnt_def);
        end
    endtask

    task automatic test_held_reset();
        logic [11:0] e;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            e = exp_q.pop_front();
            n_cmp++;
            if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
                n_fail++;
                $display("FAIL held_reset[%0d] got=%h required=%h", i, {cnt_def, cnt_dec, cnt_st3}, e);
            end
        end
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
            n_fail++;
            $display("FAIL held_release got=%h required=%h", {cnt_def, cnt_dec, cnt_st3}, e);
        end
    endtask

    task automatic test_sync();
        logic [11:0] e;
        for (int i = 0; i < 4; i++) begin
            // pulse reset entirely between edges: count must not move
            #1 reset = 1'b1;
            #2 reset = 1'b0;
            n_cmp++;
            if ({cnt_def, cnt_dec, cnt_st3} !== {4'(m_def), 4'(m_dec), 4'(m_st3)}) begin
                n_fail++;
                $display("FAIL sync_hold[%0d] got=%h required=%h", i, {cnt_def, cnt_dec, cnt_st3},
                         {4'(m_def), 4'(m_dec), 4'(m_st3)});
            end
            tick(1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
                n_fail++;
                $display("FAIL sync_count[%0d] got=%h required=%h", i, {cnt_def, cnt_dec, cnt_st3}, e);
            end
        end
    endtask

    task automatic test_variant();
        logic [11:0] e;
        tick(1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 25; i++) begin
            tick(1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
                n_fail++;
                $display("FAIL variant_seq[%0d] got=%h required=%h", i, {cnt_def, cnt_dec, cnt_st3}, e);
            end
            n_cmp++;
            if (cnt_dec > 4'd9) begin
                n_fail++;
                $display("FAIL decade_range[%0d] got=%0d required<=9", i, cnt_dec);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        logic        r;
        for (int i = 0; i < 40; i++) begin
            r = ($urandom_range(0, 7) == 0);
            tick(r);
            e = exp_q.pop_front();
            n_cmp++;
            if ({cnt_def, cnt_dec, cnt_st3} !== e) begin
                n_fail++;
                $display("FAIL random_seq[%0d] got=%h required=%h", i, {cnt_def, cnt_dec, cnt_st3}, e);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_wrap();
        test_mid_reset();
        test_held_reset();
        test_sync();
        test_variant();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
